wave_period_analyzer: RTL and testbench
=======================================

# wave_period_analyzer

Receive-side measurement block for the function-generator datapath. Consumes the signed 8-bit sample stream produced by the sine/waveform generators and detects rising mid-level crossings with hysteresis. Measures the period in samples plus the signed min/max of each complete period, and presents one registered result per period with a single-cycle valid strobe. Sits downstream of the generator and drives display/checking logic.

## Interface
- W, 8: sample width, signed two's complement
- CW, 16: period counter / period output width
- HYST, 4: hysteresis threshold magnitude, signed compare, 0 < HYST < 2^(W-1)

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- sample_valid  input  1  sample accepted on a clk edge where this is 1
- sample  input  W  signed sample
- period  output  CW  samples in last completed period
- peak_max  output  W  signed max over last completed period
- peak_min  output  W  signed min over last completed period
- overflow  output  1  last period count saturated
- result_valid  output  1  one-cycle strobe: new period/peak_max/peak_min/overflow
- locked  output  1  a crossing has been seen and a measurement is running

## Operation
- Low condition: sample <= -HYST. High condition: sample >= +HYST. Both compares are signed. Samples strictly between the thresholds never change state.
- Only accepted samples (sample_valid=1) advance state, count, or peaks. With sample_valid=0, all registers hold.
- FSM states:
  - SEEK_LOW (reset state): on a low sample -> SEEK_RISE.
  - SEEK_RISE: on a high sample -> RUN_HIGH. Load cnt=1, max=min=sample.
  - RUN_HIGH: on every sample, cnt++ (saturating) and update max/min. A low sample also -> RUN_LOW.
  - RUN_LOW: a high sample is a rising crossing:
    - publish period=cnt, peak_max=max, peak_min=min, overflow=sat;
    - pulse result_valid;
    - reload cnt=1, max=min=sample, sat=0;
    - -> RUN_HIGH.
  - RUN_LOW, any other sample: cnt++ (saturating) and update max/min.
- The period spans from the crossing sample up to the sample before the next crossing. The next crossing sample belongs to the next period.
- cnt saturates at 2^CW-1 and sets sat. On publish with sat=1, period=2^CW-1 and overflow=1.
- locked=1 in RUN_HIGH/RUN_LOW, 0 otherwise.
- No timeout: a stalled waveform leaves the FSM in its RUN state with saturated cnt until the next crossing.

## Timing
- Reset (rst=0, asynchronous):
  - state=SEEK_LOW;
  - period, peak_max, peak_min, overflow, result_valid, locked = 0;
  - internal cnt/max/min/sat = 0.
- Reset mid-period discards the partial measurement. The first result after release needs low -> high (arm) and then a full period.
- Result latency: result_valid and the new result values are visible in the cycle after the edge that accepts the crossing sample. result_valid is high for exactly one cycle.
- Result outputs hold until the next publish.
- Back-to-back results are possible only at the minimum period of 2 accepted samples (high, low, high).
- locked rises in the cycle after the edge accepting the first high sample in SEEK_RISE.

## Test plan
- Reset: hold rst=0 with random samples/valid -> all outputs 0. Release with sample=0 constant -> no result_valid, locked=0.
- Square stream, sample_valid=1 every cycle, +100×5 then -100×5 repeating, starting low:
  - first result_valid 1 cycle after the 2nd rising crossing: period=10, peak_max=100, peak_min=-100, overflow=0;
  - then one strobe every 10 cycles.
- Same stream with sample_valid=1 every other cycle (zeros on invalid cycles) -> identical results, strobes every 20 cycles.
- Hysteresis, HYST=4: samples alternating +3/-3 for 100 cycles -> no result_valid, locked=0. Then +4/-4 alternating -> period=2, peak_max=4, peak_min=-4.
- Overflow, CW=4: arm low, 1 high sample, 20 low samples, then high -> period=15, overflow=1. The next clean 10-sample period gives period=10, overflow=0.
- Reset mid-run: after 2 results, assert rst for 1 cycle mid-period -> outputs 0 and locked=0. The next result appears only after re-arm plus a full period, with correct period=10.

Source files
------------

// File: rtl/wave_period_analyzer_if.sv
// ---------------------------------------------------------------------------
// wave_period_analyzer_if
// Sample stream in, per-period measurement out.
//   master : drives sample_valid/sample, observes the result signals
//   slave  : the analyzer; consumes samples, drives the result signals
// Signals:
//   sample_valid  sample accepted on a clk edge where this is 1
//   sample        signed W-bit sample
//   period        samples in last completed period (CW bits)
//   peak_max/min  signed extremes over the last completed period
//   overflow      last period count saturated
//   result_valid  one-cycle strobe marking a new result
//   locked        a crossing has been seen and a measurement is running
// ---------------------------------------------------------------------------
interface wave_period_analyzer_if #(
    parameter int W  = 8,
    parameter int CW = 16
);
    logic                sample_valid;
    logic signed [W-1:0] sample;
    logic [CW-1:0]       period;
    logic signed [W-1:0] peak_max;
    logic signed [W-1:0] peak_min;
    logic                overflow;
    logic                result_valid;
    logic                locked;

    modport master (
        output sample_valid, sample,
        input  period, peak_max, peak_min, overflow, result_valid, locked
    );

    modport slave (
        input  sample_valid, sample,
        output period, peak_max, peak_min, overflow, result_valid, locked
    );
endinterface

// File: rtl/wave_period_analyzer.sv
// ---------------------------------------------------------------------------
// wave_period_analyzer
// Detects rising mid-level crossings (with +/-HYST hysteresis) on a signed
// sample stream, measures the period in accepted samples plus the signed
// min/max over each complete period, and publishes one registered result
// per period with a single-cycle result_valid strobe.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   wave_period_analyzer_if.slave (sample in, results out)
// ---------------------------------------------------------------------------
module wave_period_analyzer #(
    parameter int W    = 8,
    parameter int CW   = 16,
    parameter int HYST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    wave_period_analyzer_if.slave   bus
);
    localparam logic signed [W-1:0] HI_T    = W'(HYST);
    localparam logic signed [W-1:0] LO_T    = W'(-HYST);
    localparam logic [CW-1:0]       CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {SEEK_LOW, SEEK_RISE, RUN_HIGH, RUN_LOW} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [W-1:0] max_q, max_d, min_q, min_d;
    logic                sat_q, sat_d;
    logic [CW-1:0]       period_q;
    logic signed [W-1:0] pmax_q, pmin_q;
    logic                ovf_q, rv_q;

    logic is_hi, is_lo;
    logic load, incr, publish, locked;

    // Samples strictly between the thresholds are neither high nor low.
    assign is_hi = bus.sample_valid && (bus.sample >= HI_T);
    assign is_lo = bus.sample_valid && (bus.sample <= LO_T);

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SEEK_LOW;
        else      state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEEK_LOW:  if (is_lo) state_d = SEEK_RISE;
            SEEK_RISE: if (is_hi) state_d = RUN_HIGH;
            RUN_HIGH:  if (is_lo) state_d = RUN_LOW;
            RUN_LOW:   if (is_hi) state_d = RUN_HIGH;
            default:   state_d = SEEK_LOW;
        endcase
    end

    // ---- FSM: outputs / datapath controls ----
    always_comb begin
        load    = 1'b0;
        incr    = 1'b0;
        publish = 1'b0;
        locked  = 1'b0;
        unique case (state_q)
            SEEK_RISE: load = is_hi;
            RUN_HIGH: begin
                locked = 1'b1;
                incr   = bus.sample_valid;
            end
            RUN_LOW: begin
                locked  = 1'b1;
                // The crossing sample opens the next period rather than
                // closing this one, so it reloads instead of counting.
                publish = is_hi;
                load    = is_hi;
                incr    = bus.sample_valid && !is_hi;
            end
            default: ;
        endcase
    end

    // ---- measurement datapath next-state ----
    always_comb begin
        cnt_d = cnt_q;
        sat_d = sat_q;
        max_d = max_q;
        min_d = min_q;
        if (load) begin
            cnt_d = {{(CW-1){1'b0}}, 1'b1};
            sat_d = 1'b0;
            max_d = bus.sample;
            min_d = bus.sample;
        end else if (incr) begin
            // sat marks that the true count went past what cnt can hold.
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
            if (bus.sample > max_q) max_d = bus.sample;
            if (bus.sample < min_q) min_d = bus.sample;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            max_q    <= '0;
            min_q    <= '0;
            period_q <= '0;
            pmax_q   <= '0;
            pmin_q   <= '0;
            ovf_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            max_q <= max_d;
            min_q <= min_d;
            rv_q  <= publish;
            if (publish) begin
                period_q <= cnt_q;
                pmax_q   <= max_q;
                pmin_q   <= min_q;
                ovf_q    <= sat_q;
            end
        end
    end

    assign bus.period       = period_q;
    assign bus.peak_max     = pmax_q;
    assign bus.peak_min     = pmin_q;
    assign bus.overflow     = ovf_q;
    assign bus.result_valid = rv_q;
    assign bus.locked       = locked;
endmodule

// File: tb/tb_wave_period_analyzer.sv
module tb_wave_period_analyzer;
    localparam int HYST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sv  = 1'b0;
    logic signed [7:0] smp = '0;

    always #5 clk = ~clk;

    wave_period_analyzer_if #(.W(8), .CW(16)) b16 ();
    wave_period_analyzer_if #(.W(8), .CW(4))  b4 ();

    assign b16.sample_valid = sv;
    assign b16.sample       = smp;
    assign b4.sample_valid  = sv;
    assign b4.sample        = smp;

    wave_period_analyzer #(.W(8), .CW(16), .HYST(HYST)) u16 (.clk(clk), .rst(rst), .bus(b16));
    wave_period_analyzer #(.W(8), .CW(4),  .HYST(HYST)) u4  (.clk(clk), .rst(rst), .bus(b4));

    int n_cmp = 0;
    int n_bad = 0;
    int rv_cnt = 0;

    // Reference model: the open period is kept as the list of its samples.
    bit m_armed, m_run, m_seen_low;
    int q[$];
    bit exp_rv;
    int exp_n, exp_max, exp_min;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0; m_run = 0; m_seen_low = 0;
        q.delete();
        exp_rv = 0; exp_n = 0; exp_max = 0; exp_min = 0;
    endtask

    task automatic model_accept(input int s);
        bit lo, hi;
        lo = (s <= -HYST);
        hi = (s >= HYST);
        if (!m_run) begin
            if (!m_armed) begin
                if (lo) m_armed = 1;
            end else if (hi) begin
                m_run = 1; m_seen_low = 0;
                q.delete(); q.push_back(s);
            end
        end else if (m_seen_low && hi) begin
            exp_rv = 1;
            exp_n = q.size();
            exp_max = q[0]; exp_min = q[0];
            foreach (q[i]) begin
                if (q[i] > exp_max) exp_max = q[i];
                if (q[i] < exp_min) exp_min = q[i];
            end
            q.delete(); q.push_back(s);
            m_seen_low = 0;
        end else begin
            q.push_back(s);
            if (lo) m_seen_low = 1;
        end
    endtask

    function automatic logic [34:0] expv(input int cw);
        int maxc, p;
        maxc = (1 << cw) - 1;
        p = (exp_n > maxc) ? maxc : exp_n;
        return {exp_rv, m_run, (exp_n > maxc), 16'(p), 8'(exp_max), 8'(exp_min)};
    endfunction

    function automatic logic [34:0] pack16();
        return {b16.result_valid, b16.locked, b16.overflow, b16.period, b16.peak_max, b16.peak_min};
    endfunction

    function automatic logic [34:0] pack4();
        return {b4.result_valid, b4.locked, b4.overflow, 12'd0, b4.period, b4.peak_max, b4.peak_min};
    endfunction

    // One clock: drive, let the edge accept, then check both DUTs vs model.
    task automatic step(input logic v, input logic signed [7:0] s);
        sv = v; smp = s;
        @(posedge clk); #1;
        exp_rv = 0;
        if (v) model_accept(int'(s));
        if (b16.result_valid) rv_cnt++;
        chk("cyc16", 64'(pack16()), 64'(expv(16)));
        chk("cyc4",  64'(pack4()),  64'(expv(4)));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            sv = 1'($urandom_range(0, 1)); smp = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("rst16", 64'(pack16()), 64'd0);
            chk("rst4",  64'(pack4()),  64'd0);
        end
        model_reset();
        rv_cnt = 0;
        rst = 1'b1;
    endtask

    task automatic square(input int periods, input bit half);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, (i < 5) ? -8'sd100 : 8'sd100);
                if (half) step(1'b0, 8'sd0);
            end
        end
    endtask

    typedef struct {
        logic v; logic signed [7:0] s;
        logic rv; logic lk; logic [15:0] p; logic signed [7:0] mx; logic signed [7:0] mn;
    } vec_t;
    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1,  8'sd3,   1'b0, 1'b0, 16'd0, 8'sd0, 8'sd0};
        tbl[1]  = '{1'b1, -8'sd3,   1'b0, 1'b0, 16'd0, 8'sd0, 8'sd0};
        tbl[2]  = '{1'b1, -8'sd4,   1'b0, 1'b0, 16'd0, 8'sd0, 8'sd0};
        tbl[3]  = '{1'b1,  8'sd4,   1'b0, 1'b1, 16'd0, 8'sd0, 8'sd0};
        tbl[4]  = '{1'b1, -8'sd4,   1'b0, 1'b1, 16'd0, 8'sd0, 8'sd0};
        tbl[5]  = '{1'b1,  8'sd4,   1'b1, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[6]  = '{1'b1, -8'sd4,   1'b0, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[7]  = '{1'b1,  8'sd4,   1'b1, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[8]  = '{1'b1,  8'sd3,   1'b0, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[9]  = '{1'b1, -8'sd3,   1'b0, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[10] = '{1'b1, -8'sd4,   1'b0, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[11] = '{1'b0,  8'sd100, 1'b0, 1'b1, 16'd2, 8'sd4, -8'sd4};
        tbl[12] = '{1'b1,  8'sd4,   1'b1, 1'b1, 16'd4, 8'sd4, -8'sd4};
        tbl[13] = '{1'b0, -8'sd100, 1'b0, 1'b1, 16'd4, 8'sd4, -8'sd4};

        // Reset held with random inputs, then quiet release.
        model_reset();
        do_reset(6);
        for (int i = 0; i < 5; i++) step(1'b1, 8'sd0);

        // Table-driven hysteresis / minimum-period vectors.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].s);
            chk($sformatf("tbl%0d", i), 64'(pack16()),
                64'({tbl[i].rv, tbl[i].lk, 1'b0, tbl[i].p, tbl[i].mx, tbl[i].mn}));
        end

        // Full-rate square wave.
        do_reset(1);
        square(6, 1'b0);
        chk("sq_cnt", 64'(rv_cnt), 64'd5);
        chk("sq_res", {b16.period, b16.peak_max, b16.peak_min, b16.overflow},
            {16'd10, 8'sd100, -8'sd100, 1'b0});

        // Half-rate square wave.
        do_reset(1);
        square(6, 1'b1);
        chk("half_cnt", 64'(rv_cnt), 64'd5);
        chk("half_p", 64'(b16.period), 64'd10);

        // Sub-threshold chatter never arms, then threshold-level swing does.
        do_reset(1);
        for (int i = 0; i < 100; i++) step(1'b1, (i % 2) ? -8'sd3 : 8'sd3);
        chk("hyst_lk", 64'(b16.locked), 64'd0);
        chk("hyst_cnt", 64'(rv_cnt), 64'd0);
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) ? 8'sd4 : -8'sd4);
        chk("hyst_res", {b16.period, b16.peak_max, b16.peak_min}, {16'd2, 8'sd4, -8'sd4});

        // Saturation on the CW=4 instance.
        do_reset(1);
        step(1'b1, -8'sd100);
        step(1'b1, 8'sd100);
        for (int i = 0; i < 20; i++) step(1'b1, -8'sd100);
        step(1'b1, 8'sd100);
        chk("ovf4", {b4.result_valid, b4.period, b4.overflow}, {1'b1, 4'd15, 1'b1});
        chk("ovf16", {b16.period, b16.overflow}, {16'd21, 1'b0});
        for (int i = 0; i < 4; i++) step(1'b1, 8'sd100);
        for (int i = 0; i < 5; i++) step(1'b1, -8'sd100);
        step(1'b1, 8'sd100);
        chk("ovf4_clr", {b4.result_valid, b4.period, b4.overflow}, {1'b1, 4'd10, 1'b0});

        // Reset mid-run, asynchronous, between edges.
        do_reset(1);
        square(3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, -8'sd100);
        #3 rst = 1'b0;
        #1;
        chk("midrst16", 64'(pack16()), 64'd0);
        chk("midrst4",  64'(pack4()),  64'd0);
        @(posedge clk); #1;
        model_reset();
        rv_cnt = 0;
        rst = 1'b1;
        square(3, 1'b0);
        chk("rearm_cnt", 64'(rv_cnt), 64'd2);
        chk("rearm_p", 64'(b16.period), 64'd10);

        // Randomized: noisy samples and random-length square segments.
        do_reset(1);
        for (int k = 0; k < 200; k++) begin
            int hl, ll;
            logic signed [7:0] hs, ls;
            hl = $urandom_range(1, 12);
            ll = $urandom_range(1, 25);
            for (int i = 0; i < hl; i++) begin
                hs = 8'($urandom_range(HYST - 1, 127));
                step(1'($urandom_range(0, 3) != 0), hs);
            end
            for (int i = 0; i < ll; i++) begin
                ls = 8'(-int'($urandom_range(HYST - 1, 128)));
                step(1'($urandom_range(0, 3) != 0), ls);
            end
            if (k % 40 == 0) begin
                for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
